// File: rtl/charlieplex_pkg.sv
// Shared constants, state encoding and index helpers for the charlieplexed LED scanner.
package charlieplex_pkg;

    localparam int N_MATRICES = 2;
    localparam int N_PINS     = 9;
    localparam int N_COLS     = 8;
    localparam int N_LEDS     = N_MATRICES * N_PINS * N_COLS;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_e;

    // Bit position of LED (m, r, c) inside the flat on/off vector.
    function automatic logic [7:0] led_index(input int m, input logic [3:0] r, input logic [2:0] c);
        return 8'(m * N_PINS * N_COLS + int'(r) * N_COLS + int'(c));
    endfunction

    // Columns skip over the row pin, so the row pin is never used as a column.
    function automatic logic [3:0] col_to_pin(input logic [3:0] r, input logic [2:0] c);
        return ({1'b0, c} < r) ? {1'b0, c} : ({1'b0, c} + 4'd1);
    endfunction

endpackage

// File: rtl/charlieplex_row_decode.sv
// One 9-pin sub-matrix: row number plus lit-column mask to per-pin enable and drive value.
module charlieplex_row_decode
    import charlieplex_pkg::*;
(
    input  logic [3:0]        row_i,
    input  logic [N_COLS-1:0] cols_i,
    output logic [N_PINS-1:0] oe_o,
    output logic [N_PINS-1:0] out_o
);

    always_comb begin
        oe_o  = '0;
        out_o = '0;
        if (row_i < 4'(N_PINS)) begin
            oe_o[row_i]  = 1'b1;
            out_o[row_i] = 1'b1;
            // Lit columns sink current: enabled and driven low.
            for (int c = 0; c < N_COLS; c++) begin
                if (cols_i[c]) begin
                    oe_o[col_to_pin(row_i, 3'(c))] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/charlieplex_scan.sv
// Row scanner for two parallel 9-pin charlieplexed matrices with blanking between rows.
//   state | meaning
//   IDLE  | scan disabled, all pins hi-Z, row held at 0
//   BLANK | all pins hi-Z for BLANK_CYCLES before the current row is driven
//   DRIVE | row pins high, lit columns low, for DWELL_CYCLES
module charlieplex_scan
    import charlieplex_pkg::*;
#(
    parameter int DWELL_CYCLES = 256,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       aclr,
    input  logic                       enable,
    input  logic [N_LEDS-1:0]          led_state,
    output logic [N_MATRICES*N_PINS-1:0] pin_out,
    output logic [N_MATRICES*N_PINS-1:0] pin_oe,
    output logic [3:0]                 row,
    output logic                       frame_start
);

    localparam int CNT_MAX = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [3:0]       LAST_ROW   = 4'(N_PINS - 1);

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [3:0]                           row_q, row_d;
    logic [N_MATRICES-1:0][N_COLS-1:0]    snap_q, snap_d;
    logic                                 fs_q, fs_d;
    logic [N_MATRICES-1:0][N_PINS-1:0]    pin_oe_q, pin_oe_d;
    logic [N_MATRICES-1:0][N_PINS-1:0]    pin_out_q, pin_out_d;
    logic [N_MATRICES-1:0][N_PINS-1:0]    dec_oe, dec_out;

    always_ff @(posedge clock) begin
        if (aclr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            snap_q    <= '0;
            fs_q      <= 1'b0;
            pin_oe_q  <= '0;
            pin_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            snap_q    <= snap_d;
            fs_q      <= fs_d;
            pin_oe_q  <= pin_oe_d;
            pin_out_q <= pin_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        snap_d  = snap_q;
        fs_d    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = BLANK_LOAD;
                    row_d   = '0;
                    fs_d    = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = DRIVE;
                        cnt_d   = DWELL_LOAD;
                        // Row pattern is frozen here so a row never tears mid-dwell.
                        for (int m = 0; m < N_MATRICES; m++) begin
                            snap_d[m] = led_state[led_index(m, row_q, 3'd0) +: N_COLS];
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        state_d = BLANK;
                        cnt_d   = BLANK_LOAD;
                        row_d   = (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;
                        fs_d    = (row_q == LAST_ROW);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            endcase
        end
    end

    for (genvar m = 0; m < N_MATRICES; m++) begin : g_dec
        charlieplex_row_decode u_dec (
            .row_i  (row_d),
            .cols_i (snap_d[m]),
            .oe_o   (dec_oe[m]),
            .out_o  (dec_out[m])
        );
    end

    always_comb begin
        pin_oe_d  = '0;
        pin_out_d = '0;
        if (state_d == DRIVE) begin
            pin_oe_d  = dec_oe;
            pin_out_d = dec_out;
        end
    end

    assign pin_oe      = pin_oe_q;
    assign pin_out     = pin_out_q;
    assign row         = row_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_charlieplex_scan.sv
// Directed bench for charlieplex_scan with BLANK_CYCLES=2, DWELL_CYCLES=4 (54-cycle frame).
module tb_charlieplex_scan;

    logic          clock;
    logic          aclr;
    logic          enable;
    logic [143:0]  led_state;
    logic [17:0]   pin_out;
    logic [17:0]   pin_oe;
    logic [3:0]    row;
    logic          frame_start;

    int tests_run = 0;
    int tests_failed = 0;

    charlieplex_scan #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clock       (clock),
        .aclr        (aclr),
        .enable      (enable),
        .led_state   (led_state),
        .pin_out     (pin_out),
        .pin_oe      (pin_oe),
        .row         (row),
        .frame_start (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string         name;
        logic [143:0]  led;
        int            off;
        logic [17:0]   oe;
        logic [17:0]   out;
        logic [3:0]    row;
        logic          fs;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [17:0] oe, input logic [17:0] out,
                             input logic [3:0] r, input logic fs);
        check({name, ".oe"},  32'(pin_oe),      32'(oe));
        check({name, ".out"}, 32'(pin_out),     32'(out));
        check({name, ".row"}, 32'(row),         32'(r));
        check({name, ".fs"},  32'(frame_start), 32'(fs));
    endtask

    // Leaves the bench at t0, the first cycle showing frame_start.
    task automatic start_frame(input logic [143:0] led);
        bit seen;
        aclr      = 1'b1;
        enable    = 1'b1;
        led_state = led;
        step();
        step();
        aclr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (frame_start === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL frame_start_timeout: got 0, expected 1 within 100 cycles");
        end
    endtask

    initial begin
        aclr      = 1'b1;
        enable    = 1'b0;
        led_state = '0;

        vecs[0]  = '{"r0_single_first",  144'd1,              2,  18'h00203, 18'h00201, 4'd0, 1'b0};
        vecs[1]  = '{"r0_single_last",   144'd1,              5,  18'h00203, 18'h00201, 4'd0, 1'b0};
        vecs[2]  = '{"r1_blank",         144'd1,              6,  18'h00000, 18'h00000, 4'd1, 1'b0};
        vecs[3]  = '{"r1_row_only",      144'd1,              8,  18'h00402, 18'h00402, 4'd1, 1'b0};
        vecs[4]  = '{"r8_row_only",      144'd1,              50, 18'h20100, 18'h20100, 4'd8, 1'b0};
        vecs[5]  = '{"wrap_frame",       144'd1,              54, 18'h00000, 18'h00000, 4'd0, 1'b1};
        vecs[6]  = '{"m1_r1_c0",         (144'd1 << 80),      8,  18'h00602, 18'h00402, 4'd1, 1'b0};
        vecs[7]  = '{"all_on_r4",        {144{1'b1}},         26, 18'h3FFFF, 18'h02010, 4'd4, 1'b0};
        vecs[8]  = '{"all_on_t0",        {144{1'b1}},         0,  18'h00000, 18'h00000, 4'd0, 1'b1};
        vecs[9]  = '{"m1_r8_c7",         (144'd1 << 143),     50, 18'h30100, 18'h20100, 4'd8, 1'b0};
        vecs[10] = '{"m0_r3_c3",         (144'd1 << 27),      20, 18'h01018, 18'h01008, 4'd3, 1'b0};
        vecs[11] = '{"r0_blank2",        144'd1,              1,  18'h00000, 18'h00000, 4'd0, 1'b0};
        vecs[12] = '{"m0_r2_c5",         (144'd1 << 21),      14, 18'h00844, 18'h00804, 4'd2, 1'b0};

        // Reset held with enable high, then release.
        aclr      = 1'b1;
        enable    = 1'b1;
        led_state = 144'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("reset_hold", 18'h0, 18'h0, 4'd0, 1'b0);
        end
        aclr = 1'b0;
        step();
        check_all("reset_release_t0", 18'h0, 18'h0, 4'd0, 1'b1);
        step();
        check_all("reset_release_t1", 18'h0, 18'h0, 4'd0, 1'b0);
        step();
        check_all("reset_release_t2", 18'h00203, 18'h00201, 4'd0, 1'b0);

        for (int v = 0; v < 13; v++) begin
            start_frame(vecs[v].led);
            for (int k = 0; k < vecs[v].off; k++) step();
            check_all(vecs[v].name, vecs[v].oe, vecs[v].out, vecs[v].row, vecs[v].fs);
        end

        // Snapshot: new data applied mid-DRIVE of row 2 must not appear until row 3.
        start_frame(144'd1 << 16);
        for (int k = 0; k < 15; k++) step();
        check_all("snap_before", 18'h00805, 18'h00804, 4'd2, 1'b0);
        led_state = (144'd1 << 17) | (144'd1 << 24);
        step();
        check_all("snap_hold_a", 18'h00805, 18'h00804, 4'd2, 1'b0);
        step();
        check_all("snap_hold_b", 18'h00805, 18'h00804, 4'd2, 1'b0);
        step();
        step();
        check_all("snap_blank_r3", 18'h0, 18'h0, 4'd3, 1'b0);
        step();
        step();
        check_all("snap_row3_new", 18'h01009, 18'h01008, 4'd3, 1'b0);

        // Abort via enable at t0+3, then restart.
        start_frame(144'd1);
        for (int k = 0; k < 3; k++) step();
        check_all("abort_pre", 18'h00203, 18'h00201, 4'd0, 1'b0);
        enable = 1'b0;
        step();
        check_all("abort_idle", 18'h0, 18'h0, 4'd0, 1'b0);
        step();
        step();
        check_all("abort_idle_hold", 18'h0, 18'h0, 4'd0, 1'b0);
        enable = 1'b1;
        step();
        check_all("reenable_t0", 18'h0, 18'h0, 4'd0, 1'b1);
        step();
        step();
        check_all("reenable_t2", 18'h00203, 18'h00201, 4'd0, 1'b0);

        // Reset mid-DRIVE behaves like the abort.
        step();
        aclr = 1'b1;
        step();
        check_all("aclr_mid_drive", 18'h0, 18'h0, 4'd0, 1'b0);
        aclr = 1'b0;
        step();
        check_all("aclr_restart_t0", 18'h0, 18'h0, 4'd0, 1'b1);
        step();
        step();
        check_all("aclr_restart_t2", 18'h00203, 18'h00201, 4'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
